// File: rtl/window_line_buffer.sv
// Streaming KxK neighbourhood generator for raster-order pixel streams.
// Keeps K-1 previous rows in cascaded line buffers; emits interior windows only.
module window_line_buffer #(
    parameter int K      = 5,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    input  logic [DATA_W-1:0]                 i_pixel,
    input  logic                              i_sof,
    output logic                              o_valid,
    output logic [K-1:0][K-1:0][DATA_W-1:0]   window,
    output logic [$clog2(IMG_W)-1:0]          o_x,
    output logic [$clog2(IMG_H)-1:0]          o_y
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int HALF = (K - 1) / 2;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(K - 1);
    localparam logic [XW-1:0] X_OFF  = XW'(HALF);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(K - 1);
    localparam logic [YW-1:0] Y_OFF  = YW'(HALF);

    if (K % 2 == 0 || K < 3 || IMG_W < K || IMG_H < K) begin : g_bad_param
        $error("window_line_buffer: illegal K/IMG_W/IMG_H combination");
    end

    logic [XW-1:0]     col;
    logic [XW-1:0]     c;
    logic [XW-1:0]     c_next;
    logic [YW-1:0]     row;
    logic [YW-1:0]     r;
    logic [YW-1:0]     r_next;
    logic              win_ok;

    logic [DATA_W-1:0] lb    [K-1][IMG_W];
    logic [DATA_W-1:0] lb_rd [K-1];

    // A start-of-frame pixel overrides the running position.
    always_comb begin
        c      = i_sof ? '0 : col;
        r      = i_sof ? '0 : row;
        c_next = c + 1'b1;
        r_next = r;
        if (c == X_LAST) begin
            c_next = '0;
            r_next = (r == Y_LAST) ? '0 : r + 1'b1;
        end
        win_ok = (c >= X_MIN) && (r >= Y_MIN);
    end

    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_rd[j] = lb[j][c];
        end
    end

    // Line buffers are not reset; row gating keeps stale data hidden.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb[0][c] <= i_pixel;
            for (int j = 0; j < K - 2; j++) begin
                lb[j+1][c] <= lb_rd[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            o_valid <= 1'b0;
            window  <= '0;
            o_x     <= '0;
            o_y     <= '0;
        end else begin
            o_valid <= i_valid && win_ok;
            if (i_valid) begin
                col <= c_next;
                row <= r_next;
                for (int rr = 0; rr < K; rr++) begin
                    for (int kk = 0; kk < K - 1; kk++) begin
                        window[rr][kk] <= window[rr][kk+1];
                    end
                end
                window[K-1][K-1] <= i_pixel;
                for (int j = 0; j < K - 1; j++) begin
                    window[K-2-j][K-1] <= lb_rd[j];
                end
                if (win_ok) begin
                    o_x <= c - X_OFF;
                    o_y <= r - Y_OFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer with K=3 on an 8x6 image.
// Pixels are (y<<4)|x, optionally tagged 0x80 for a second frame.
module tb_window_line_buffer;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         i_valid = 1'b0;
    logic [DW-1:0]                i_pixel = '0;
    logic                         i_sof = 1'b0;
    logic                         o_valid;
    logic [K-1:0][K-1:0][DW-1:0]  window;
    logic [2:0]                   o_x;
    logic [2:0]                   o_y;

    window_line_buffer #(.K(K), .DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_pixel (i_pixel),
        .i_sof   (i_sof),
        .o_valid (o_valid),
        .window  (window),
        .o_x     (o_x),
        .o_y     (o_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    bit                          mon_en = 1'b0;
    int                          pulse_cnt = 0;
    logic                        acc_q = 1'b0;
    logic [3:0]                  acc_x_q = '0;
    logic [K-1:0][K-1:0][DW-1:0] cap_win [64];
    logic [2:0]                  cap_x   [64];
    logic [2:0]                  cap_y   [64];

    always @(posedge clk) begin
        acc_q <= i_valid;
        if (i_valid) acc_x_q <= i_pixel[3:0];
    end

    always @(negedge clk) begin
        if (mon_en && o_valid) begin
            int idx;
            int ex;
            int ey;
            logic [7:0] base;
            idx  = pulse_cnt % 48;
            ex   = 1 + (idx % 24) % 6;
            ey   = 1 + (idx % 24) / 6;
            base = (idx >= 24) ? 8'h80 : 8'h00;
            chk("accepted_before", 32'(acc_q), 32'd1);
            chk("no_row_wrap", 32'(acc_x_q >= 4'd2), 32'd1);
            chk("o_x", 32'(o_x), 32'(ex));
            chk("o_y", 32'(o_y), 32'(ey));
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    logic [7:0] e;
                    e = base | 8'(((ey - 1 + r) << 4) | (ex - 1 + k));
                    chk($sformatf("win%0d%0d_p%0d", r, k, pulse_cnt),
                        32'(window[r][k]), 32'(e));
                end
            end
            if (pulse_cnt < 64) begin
                cap_win[pulse_cnt] = window;
                cap_x[pulse_cnt]   = o_x;
                cap_y[pulse_cnt]   = o_y;
            end
            pulse_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_sof   = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] p, input bit sof, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 99) < 40) idle(1);
        end
        @(negedge clk);
        i_valid = 1'b1;
        i_pixel = p;
        i_sof   = sof;
    endtask

    // Streams npix pixels; pixels beyond the first frame carry the 0x80 tag.
    task automatic stream(input int npix, input bit sof_first, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] p;
            p = 8'(((i / W) % H) << 4) | 8'(i % W);
            if (i >= W * H) p = p | 8'h80;
            push(p, sof_first && (i == 0), gaps);
        end
        idle(3);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_window", 32'(window != '0), 32'd0);
        chk("rst_o_x", 32'(o_x), 32'd0);
        chk("rst_o_y", 32'(o_y), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Continuous full frame
        mon_en = 1'b1;
        pulse_cnt = 0;
        stream(W * H, 1'b1, 1'b0);
        chk("s1_pulses", 32'(pulse_cnt), 32'd24);
        chk("s1_first_00", 32'(cap_win[0][0][0]), 32'h00);
        chk("s1_first_11", 32'(cap_win[0][1][1]), 32'h11);
        chk("s1_first_22", 32'(cap_win[0][2][2]), 32'h22);
        chk("s1_first_x", 32'(cap_x[0]), 32'd1);
        chk("s1_first_y", 32'(cap_y[0]), 32'd1);
        chk("s1_last_22", 32'(cap_win[23][2][2]), 32'h57);
        chk("s1_last_x", 32'(cap_x[23]), 32'd6);
        chk("s1_last_y", 32'(cap_y[23]), 32'd4);
        chk("s1_row3_00", 32'(cap_win[6][0][0]), 32'h10);
        chk("s1_row3_20", 32'(cap_win[6][2][0]), 32'h30);
        chk("s1_row3_22", 32'(cap_win[6][2][2]), 32'h32);
        chk("s1_row3_x", 32'(cap_x[6]), 32'd1);
        chk("s1_row3_y", 32'(cap_y[6]), 32'd2);

        // Random idle gaps
        pulse_cnt = 0;
        stream(W * H, 1'b1, 1'b1);
        chk("s2_pulses", 32'(pulse_cnt), 32'd24);

        // Garbage prefix, then i_sof on the 20th pixel
        mon_en = 1'b0;
        for (int i = 0; i < 19; i++) push(8'hEE, 1'b0, 1'b0);
        idle(3);
        mon_en = 1'b1;
        pulse_cnt = 0;
        stream(W * H, 1'b1, 1'b0);
        chk("s3_pulses", 32'(pulse_cnt), 32'd24);
        chk("s3_first_22", 32'(cap_win[0][2][2]), 32'h22);

        // Reset while streaming row 4
        mon_en = 1'b0;
        for (int i = 0; i < 4 * W + 3; i++) begin
            push(8'(((i / W) << 4) | (i % W)), i == 0, 1'b0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        rst     = 1'b1;
        #1;
        chk("s4_rst_o_valid", 32'(o_valid), 32'd0);
        chk("s4_rst_window", 32'(window != '0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        pulse_cnt = 0;
        stream(W * H, 1'b0, 1'b0);
        chk("s4_pulses", 32'(pulse_cnt), 32'd24);

        // Two back-to-back frames, second one without i_sof
        pulse_cnt = 0;
        stream(2 * W * H, 1'b1, 1'b0);
        chk("s5_pulses", 32'(pulse_cnt), 32'd48);
        chk("s5_f2_00", 32'(cap_win[24][0][0]), 32'h80);
        chk("s5_f2_22", 32'(cap_win[24][2][2]), 32'hA2);
        chk("s5_f2_x", 32'(cap_x[24]), 32'd1);
        chk("s5_f2_y", 32'(cap_y[24]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
